// File: rtl/adam_aes_sbox_pipe_pkg.sv
// rtl/adam_aes_sbox_pipe_pkg.sv - AES forward/inverse S-box tables and byte lookup helper
package adam_aes_pkg;

    localparam int BYTE_W = 8;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        return inv ? INV_SBOX[b] : SBOX[b];
    endfunction

endpackage

// File: rtl/adam_aes_sbox_pipe_if.sv
// rtl/adam_aes_sbox_pipe_if.sv - input/output stream handshake bundle for the S-box engine
interface adam_aes_sbox_pipe_if #(
    parameter int LANES = 4,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic                 in_inv;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_data, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/adam_aes_sbox_pipe_lane.sv
// rtl/adam_aes_sbox_pipe_lane.sv - one combinational forward/inverse S-box byte lane
module adam_aes_sbox_lane
    import adam_aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);
    assign data_o = sub_byte(data_i, inv_i);
endmodule

// File: rtl/adam_aes_sbox_pipe.sv
// rtl/adam_aes_sbox_pipe.sv - pipelined multi-lane AES S-box engine with full backpressure
module adam_aes_sbox_pipe
    import adam_aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    adam_aes_sbox_pipe_if.slave  bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_cnt
);
    localparam int DW = BYTE_W * LANES;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic             inv;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [STAGES-1:0] v_q, v_d, load, src_v;
    entry_t            st_q  [STAGES];
    entry_t            st_d  [STAGES];
    entry_t            src   [STAGES];
    logic [DW-1:0]     lk_data, sub_data;
    logic              lk_inv;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready, accept, out_fire;

    // A stage may load if it or any stage downstream of it has a hole, or the output drains.
    always_comb begin : advance
        logic hole;
        hole = 1'b0;
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            hole = bus.out_ready;
            for (int j = k; j < STAGES; j++) begin
                hole = hole | ~v_q[j];
            end
            load[k] = hole;
        end
    end

    assign in_ready = load[0] & ~flush & ~rst;
    assign accept   = bus.in_valid & in_ready;
    assign out_fire = v_q[STAGES-1] & bus.out_ready & ~flush;

    always_comb begin
        src_v = '0;
        for (int k = 0; k < STAGES; k++) begin
            src[k] = '0;
        end
        src[0].data = bus.in_data;
        src[0].inv  = bus.in_inv;
        src[0].tag  = bus.in_tag;
        src_v[0]    = accept;
        for (int k = 1; k < STAGES; k++) begin
            src[k]   = st_q[k-1];
            src_v[k] = v_q[k-1];
        end
    end

    // Substitution always sits in front of the last stage; STAGES=2 registers raw input first.
    assign lk_data = src[STAGES-1].data;
    assign lk_inv  = src[STAGES-1].inv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        adam_aes_sbox_lane u_lane (
            .data_i (lk_data[BYTE_W*i +: BYTE_W]),
            .inv_i  (lk_inv),
            .data_o (sub_data[BYTE_W*i +: BYTE_W])
        );
    end

    always_comb begin
        v_d   = v_q;
        cnt_d = cnt_q;
        for (int k = 0; k < STAGES; k++) begin
            st_d[k] = st_q[k];
            if (load[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    st_d[k] = src[k];
                end
            end
        end
        if (load[STAGES-1] && src_v[STAGES-1]) begin
            st_d[STAGES-1].data = sub_data;
        end
        if (flush) begin
            v_d = '0;
        end
        if (out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_data  = st_q[STAGES-1].data;
    assign bus.out_tag   = st_q[STAGES-1].tag;
    assign busy          = |v_q;
    assign done_cnt      = cnt_q;
endmodule

// File: tb/tb_adam_aes_sbox_pipe.sv
// tb/tb_adam_aes_sbox_pipe.sv - self-checking bench for adam_aes_sbox_pipe
module tb_adam_aes_sbox_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush_a, flush_b;
    logic        busy_a, busy_b;
    logic [3:0]  cnt_a_o;
    logic [15:0] cnt_b_o;

    adam_aes_sbox_pipe_if #(.LANES(4),  .TAG_W(4)) bus_a ();
    adam_aes_sbox_pipe_if #(.LANES(16), .TAG_W(4)) bus_b ();

    adam_aes_sbox_pipe #(.LANES(4), .STAGES(1), .TAG_W(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .bus(bus_a), .busy(busy_a), .done_cnt(cnt_a_o));
    adam_aes_sbox_pipe #(.LANES(16), .STAGES(2), .TAG_W(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .bus(bus_b), .busy(busy_b), .done_cnt(cnt_b_o));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]   fwd  [256];
    logic [7:0]   rinv [256];
    logic [131:0] qa[$], qb[$];
    int           exp_cnt_a, exp_cnt_b;
    logic [127:0] capb_data[$];
    logic [3:0]   capb_tag[$];
    int           capb_cyc[$], b_in_cyc[$];

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input int lanes);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < lanes; i++) r[8*i +: 8] = inv ? rinv[d[8*i +: 8]] : fwd[d[8*i +: 8]];
        return r;
    endfunction

    // Scoreboard: expected results enqueued at input handshake, checked at output handshake.
    always @(negedge clk) begin
        logic [131:0] e;
        if (rst) begin
            qa.delete(); exp_cnt_a = 0;
        end else if (flush_a) begin
            qa.delete();
        end else begin
            if (bus_a.out_valid && bus_a.out_ready) begin
                check("a_out_has_pending", 128'(qa.size() != 0), 128'd1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check("a_out_data", 128'(bus_a.out_data), e[127:0]);
                    check("a_out_tag", 128'(bus_a.out_tag), 128'(e[131:128]));
                end
                exp_cnt_a = (exp_cnt_a + 1) % 16;
            end
            if (bus_a.in_valid && bus_a.in_ready)
                qa.push_back({bus_a.in_tag, model(128'(bus_a.in_data), bus_a.in_inv, 4)});
        end
        if (rst) begin
            qb.delete(); exp_cnt_b = 0;
        end else if (flush_b) begin
            qb.delete();
        end else begin
            if (bus_b.out_valid && bus_b.out_ready) begin
                check("b_out_has_pending", 128'(qb.size() != 0), 128'd1);
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    check("b_out_data", bus_b.out_data, e[127:0]);
                    check("b_out_tag", 128'(bus_b.out_tag), 128'(e[131:128]));
                end
                capb_data.push_back(bus_b.out_data);
                capb_tag.push_back(bus_b.out_tag);
                capb_cyc.push_back(cyc);
                exp_cnt_b = (exp_cnt_b + 1) % 65536;
            end
            if (bus_b.in_valid && bus_b.in_ready) begin
                qb.push_back({bus_b.in_tag, model(bus_b.in_data, bus_b.in_inv, 16)});
                b_in_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic inv, input logic [3:0] tag);
        logic hs;
        hs = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_inv = inv; bus_a.in_tag = tag;
        for (int t = 0; t < 50 && !hs; t++) begin
            #1; hs = bus_a.in_ready;
            tick();
        end
        bus_a.in_valid = 1'b0;
        check("a_send_accepted", 128'(hs), 128'd1);
    endtask

    task automatic send_b(input logic [127:0] d, input logic inv, input logic [3:0] tag);
        logic hs;
        hs = 1'b0;
        bus_b.in_valid = 1'b1; bus_b.in_data = d; bus_b.in_inv = inv; bus_b.in_tag = tag;
        for (int t = 0; t < 50 && !hs; t++) begin
            #1; hs = bus_b.in_ready;
            tick();
        end
        bus_b.in_valid = 1'b0;
        check("b_send_accepted", 128'(hs), 128'd1);
    endtask

    task automatic drain();
        bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
        for (int n = 0; n < 100 && (busy_a || busy_b); n++) tick();
        check("drain_busy_a", 128'(busy_a), 128'd0);
        check("drain_busy_b", 128'(busy_b), 128'd0);
    endtask

    initial begin
        logic [127:0] orig [16];
        logic [127:0] fout [16];
        logic [127:0] d, d1;
        logic         hs;
        int           sent, tag;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xi, s;
            xi = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            s = xi ^ rotl(xi, 1) ^ rotl(xi, 2) ^ rotl(xi, 3) ^ rotl(xi, 4) ^ 8'h63;
            fwd[x] = s;
            rinv[s] = 8'(x);
        end

        rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
        bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.in_inv = 0; bus_a.in_tag = '0; bus_a.out_ready = 0;
        bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.in_inv = 0; bus_b.in_tag = '0; bus_b.out_ready = 0;
        tick(); tick();
        check("rst_in_ready_a", 128'(bus_a.in_ready), 128'd0);
        check("rst_in_ready_b", 128'(bus_b.in_ready), 128'd0);
        rst = 1'b0;
        #1;
        check("rst_out_valid_a", 128'(bus_a.out_valid), 128'd0);
        check("rst_out_data_a", 128'(bus_a.out_data), 128'd0);
        check("rst_out_tag_a", 128'(bus_a.out_tag), 128'd0);
        check("rst_busy_a", 128'(busy_a), 128'd0);
        check("rst_cnt_a", 128'(cnt_a_o), 128'd0);
        check("rst_out_valid_b", 128'(bus_b.out_valid), 128'd0);
        check("rst_busy_b", 128'(busy_b), 128'd0);
        check("rst_cnt_b", 128'(cnt_b_o), 128'd0);

        // Directed forward and inverse vectors
        bus_a.out_ready = 1'b1;
        send_a(32'h0053FF01, 1'b0, 4'h3);
        check("fwd_out_valid", 128'(bus_a.out_valid), 128'd1);
        check("fwd_out_data", 128'(bus_a.out_data), 128'h63ED167C);
        check("fwd_out_tag", 128'(bus_a.out_tag), 128'h3);
        tick();
        check("fwd_done_cnt", 128'(cnt_a_o), 128'd1);
        send_a(32'h63ED00FF, 1'b1, 4'h5);
        check("inv_out_data", 128'(bus_a.out_data), 128'h0053527D);
        tick();
        check("inv_done_cnt", 128'(cnt_a_o), 128'd2);

        // Random mixed-mode stream with random backpressure on the 1-stage engine
        sent = 0;
        for (int c = 0; c < 400 && sent < 30; c++) begin
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus_a.in_valid && $urandom_range(0, 2) != 0) begin
                bus_a.in_valid = 1'b1; bus_a.in_data = $urandom;
                bus_a.in_inv = 1'($urandom_range(0, 1)); bus_a.in_tag = 4'($urandom);
            end
            #1; hs = bus_a.in_valid && bus_a.in_ready;
            tick();
            if (hs) begin sent++; bus_a.in_valid = 1'b0; end
        end
        bus_a.in_valid = 1'b0;
        check("a_rand_sent", 128'(sent), 128'd30);
        drain();
        check("a_rand_cnt", 128'(cnt_a_o), 128'(exp_cnt_a[3:0]));

        // Reset while the pipeline is full and stalled
        bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_data = $urandom;
        tick(); tick(); tick();
        rst = 1'b1; #1;
        check("midrst_in_ready", 128'(bus_a.in_ready), 128'd0);
        tick();
        rst = 1'b0; bus_a.in_valid = 1'b0; #1;
        check("midrst_out_valid", 128'(bus_a.out_valid), 128'd0);
        check("midrst_busy", 128'(busy_a), 128'd0);
        check("midrst_cnt", 128'(cnt_a_o), 128'd0);

        // 17 completions on a 4-bit counter
        bus_a.out_ready = 1'b1;
        for (int t = 0; t < 17; t++) send_a($urandom, 1'(t & 1), 4'(t));
        drain();
        check("cnt_wrap", 128'(cnt_a_o), 128'd1);

        // Round trip over all 256 byte values on the 2-stage, 16-lane engine
        capb_data.delete(); capb_tag.delete(); capb_cyc.delete(); b_in_cyc.delete();
        bus_b.out_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16*t + i);
            orig[t] = d;
            send_b(d, 1'b0, 4'(t));
        end
        drain();
        check("rt_fwd_count", 128'(capb_data.size()), 128'd16);
        for (int t = 0; t < 16; t++) fout[t] = (t < capb_data.size()) ? capb_data[t] : '0;
        capb_data.delete(); capb_tag.delete(); capb_cyc.delete(); b_in_cyc.delete();
        for (int t = 0; t < 16; t++) send_b(fout[t], 1'b1, 4'(t));
        drain();
        check("rt_inv_count", 128'(capb_data.size()), 128'd16);
        for (int t = 0; t < 16 && t < capb_data.size() && t < b_in_cyc.size(); t++) begin
            check("rt_bytes", capb_data[t], orig[t]);
            check("rt_latency", 128'(capb_cyc[t] - b_in_cyc[t]), 128'd2);
            if (t > 0) check("rt_throughput", 128'(capb_cyc[t] - capb_cyc[t-1]), 128'd1);
        end

        // Backpressure: output stalled for 5 cycles while tags 1,2,3 are offered
        capb_data.delete(); capb_tag.delete(); capb_cyc.delete(); b_in_cyc.delete();
        bus_b.out_ready = 1'b0; tag = 1;
        d1 = {$urandom, $urandom, $urandom, $urandom};
        bus_b.in_valid = 1'b1; bus_b.in_inv = 1'b0; bus_b.in_tag = 4'(tag); bus_b.in_data = d1;
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            #1; hs = bus_b.in_ready;
            tick();
            if (hs) begin
                sent++; tag++;
                bus_b.in_tag = 4'(tag); bus_b.in_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        check("bp_accepts", 128'(sent), 128'd2);
        check("bp_in_ready", 128'(bus_b.in_ready), 128'd0);
        check("bp_out_valid", 128'(bus_b.out_valid), 128'd1);
        check("bp_hold_data", bus_b.out_data, model(d1, 1'b0, 16));
        check("bp_hold_tag", 128'(bus_b.out_tag), 128'd1);
        bus_b.out_ready = 1'b1;
        for (int c = 0; c < 20 && tag < 4; c++) begin
            #1; hs = bus_b.in_ready;
            tick();
            if (hs) tag++;
        end
        bus_b.in_valid = 1'b0;
        drain();
        check("bp_out_count", 128'(capb_tag.size()), 128'd3);
        for (int i = 0; i < 3 && i < capb_tag.size(); i++)
            check("bp_tag_order", 128'(capb_tag[i]), 128'(i + 1));

        // Flush a full pipeline with a concurrent input and a ready output
        bus_b.out_ready = 1'b0;
        send_b({$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'hA);
        send_b({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'hB);
        bus_b.in_valid = 1'b1; bus_b.in_data = {$urandom, $urandom, $urandom, $urandom}; bus_b.in_tag = 4'hC;
        bus_b.out_ready = 1'b1; flush_b = 1'b1; #1;
        check("flush_in_ready", 128'(bus_b.in_ready), 128'd0);
        tick();
        flush_b = 1'b0; bus_b.in_valid = 1'b0;
        check("flush_busy", 128'(busy_b), 128'd0);
        check("flush_out_valid", 128'(bus_b.out_valid), 128'd0);
        check("flush_cnt", 128'(cnt_b_o), 128'(exp_cnt_b[15:0]));
        tick();
        check("flush_dropped", 128'(bus_b.out_valid), 128'd0);

        // Random mixed-mode stream with random backpressure on the 2-stage engine
        sent = 0;
        for (int c = 0; c < 400 && sent < 30; c++) begin
            bus_b.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus_b.in_valid && $urandom_range(0, 2) != 0) begin
                bus_b.in_valid = 1'b1; bus_b.in_data = {$urandom, $urandom, $urandom, $urandom};
                bus_b.in_inv = 1'($urandom_range(0, 1)); bus_b.in_tag = 4'($urandom);
            end
            #1; hs = bus_b.in_valid && bus_b.in_ready;
            tick();
            if (hs) begin sent++; bus_b.in_valid = 1'b0; end
        end
        bus_b.in_valid = 1'b0;
        check("b_rand_sent", 128'(sent), 128'd30);
        drain();
        check("b_rand_cnt", 128'(cnt_b_o), 128'(exp_cnt_b[15:0]));
        check("b_queue_empty", 128'(qb.size()), 128'd0);
        check("a_queue_empty", 128'(qa.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
